rv32i_lsu: RTL

- Load/store unit on the consumer side of the ALU operand path: takes the ALU-computed effective address plus RS2 store data and turns them into one memory transaction.
- Drives a request/acknowledge data-memory bus with byte enables.
- Aligns and sign- or zero-extends load data for register writeback.
- Reports misaligned accesses, illegal funct3 codes and bus timeouts instead of issuing a bad transaction.

---
 rtl/rv32i_lsu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: converts an effective address and store data into a single
// request/ack data-memory access, with load alignment/extension and error reporting.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic        busy_d, done_d, misaligned_d, fault_d, mem_req_d, mem_we_d;
  logic [31:0] load_data_d, mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;

  logic        legal, misal, timeout_hit;
  logic [31:0] lane, ext;

  // Request legality and natural alignment, judged on the live inputs
  always_comb begin
    if (is_store) legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    else          legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
    case (funct3[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = addr[1] | addr[0];
      default: misal = 1'b0;
    endcase
  end

  // Selected read lane, then sign- or zero-extension by the captured funct3
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    load_data_d  = load_data;
    misaligned_d = misaligned;
    fault_d      = fault;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_be_d     = mem_be;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          f3_d         = funct3;
          off_d        = addr[1:0];
          load_data_d  = 32'd0;
          misaligned_d = 1'b0;
          fault_d      = 1'b0;
          if (!legal) begin
            fault_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (misal) begin
            misaligned_d = 1'b1;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end else begin
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {addr[31:2], 2'b00};
            case (funct3[1:0])
              2'b00: begin
                mem_be_d    = 4'b0001 << addr[1:0];
                mem_wdata_d = {4{store_data[7:0]}};
              end
              2'b01: begin
                mem_be_d    = 4'b0011 << addr[1:0];
                mem_wdata_d = {2{store_data[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = store_data;
              end
            endcase
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          load_data_d = is_store_q ? 32'd0 : ext;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= 32'd0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      load_data  <= load_data_d;
      misaligned <= misaligned_d;
      fault      <= fault_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_be     <= mem_be_d;
    end
  end
endmodule
